// File: rtl/i2s_receiver_if.sv
// Parallel sample-pair stream from the I2S receiver to the downstream sample FIFO.
// The master drives the data and valid; the slave returns ready.
interface i2s_receiver_if;
  logic [31:0] sample_left;
  logic [31:0] sample_right;
  logic        sample_valid;
  logic        sample_ready;

  modport master (
    output sample_left,
    output sample_right,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample_left,
    input  sample_right,
    input  sample_valid,
    output sample_ready
  );
endinterface

// File: rtl/i2s_receiver.sv
// Oversampling standard-I2S receiver: deserialises MSB-first L/R words into one 32-bit pair.
// Pair is valid 3 clk after the final SCK rise is first sampled; an unaccepted pair drops the next one (sticky overrun).
module i2s_receiver #(
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           enable,
  input  logic [3:0]     sample_size,
  input  logic           sck_in,
  input  logic           ws_in,
  input  logic           sd_in,
  i2s_receiver_if.master smp,
  output logic           overrun,
  output logic           locked
);

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    LEFT,
    RIGHT
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] ws_sync;
  logic [SYNC_STAGES-1:0] sd_sync;
  logic                   sck_d;
  logic                   ws_prev;
  logic [31:0]            shreg;
  logic [5:0]             bitcnt;
  logic [5:0]             n_len;
  logic [31:0]            left_hold;

  logic                   sck_s;
  logic                   ws_s;
  logic                   sd_s;
  logic                   strobe;
  logic                   ws_edge;
  logic                   shift_en;
  logic [31:0]            shreg_app;
  logic [5:0]             bitcnt_app;
  logic [5:0]             shamt;
  logic [31:0]            len_mask;
  logic [31:0]            word_fin;
  logic                   pair_done;

  function automatic logic [5:0] word_len(input logic [3:0] code);
    case (code)
      4'd0:    word_len = 6'd8;
      4'd1:    word_len = 6'd12;
      4'd3:    word_len = 6'd16;
      4'd4:    word_len = 6'd24;
      default: word_len = 6'd32;
    endcase
  endfunction

  // All three inputs pass through identical chains so WS/SD line up with the SCK strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync <= '0;
      ws_sync  <= '0;
      sd_sync  <= '0;
      sck_d    <= 1'b0;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck_in};
      ws_sync  <= {ws_sync[SYNC_STAGES-2:0], ws_in};
      sd_sync  <= {sd_sync[SYNC_STAGES-2:0], sd_in};
      sck_d    <= sck_s;
    end
  end

  assign sck_s   = sck_sync[SYNC_STAGES-1];
  assign ws_s    = ws_sync[SYNC_STAGES-1];
  assign sd_s    = sd_sync[SYNC_STAGES-1];
  assign strobe  = sck_s & ~sck_d;
  assign ws_edge = ws_s ^ ws_prev;

  // Bit counter saturates at N; short words are left-aligned in the N-bit field.
  always_comb begin
    shift_en   = (bitcnt < n_len);
    shreg_app  = shift_en ? {shreg[30:0], sd_s} : shreg;
    bitcnt_app = shift_en ? (bitcnt + 6'd1) : bitcnt;
    shamt      = n_len - bitcnt_app;
    len_mask   = (n_len >= 6'd32) ? 32'hFFFF_FFFF : ((32'd1 << n_len) - 32'd1);
    word_fin   = (shreg_app << shamt) & len_mask;
  end

  assign pair_done = enable && (state == RIGHT) && strobe && ws_edge;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      ws_prev          <= 1'b0;
      shreg            <= '0;
      bitcnt           <= '0;
      n_len            <= '0;
      left_hold        <= '0;
      smp.sample_left  <= '0;
      smp.sample_right <= '0;
      smp.sample_valid <= 1'b0;
      overrun          <= 1'b0;
      locked           <= 1'b0;
    end else begin
      if (strobe) begin
        ws_prev <= ws_s;
      end
      if (!enable) begin
        state            <= IDLE;
        shreg            <= '0;
        bitcnt           <= '0;
        smp.sample_valid <= 1'b0;
        overrun          <= 1'b0;
        locked           <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state <= SYNC;
          end
          SYNC: begin
            // The bit riding on the WS 1->0 strobe belongs to an unseen right word.
            if (strobe && ws_edge && !ws_s) begin
              state  <= LEFT;
              locked <= 1'b1;
              bitcnt <= '0;
              n_len  <= word_len(sample_size);
            end
          end
          LEFT: begin
            if (strobe) begin
              shreg <= shreg_app;
              if (ws_edge) begin
                left_hold <= word_fin;
                bitcnt    <= '0;
                state     <= RIGHT;
              end else begin
                bitcnt <= bitcnt_app;
              end
            end
          end
          RIGHT: begin
            if (strobe) begin
              shreg <= shreg_app;
              if (ws_edge) begin
                bitcnt <= '0;
                n_len  <= word_len(sample_size);
                state  <= LEFT;
              end else begin
                bitcnt <= bitcnt_app;
              end
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase

        if (pair_done) begin
          if (!smp.sample_valid || smp.sample_ready) begin
            smp.sample_left  <= left_hold;
            smp.sample_right <= word_fin;
            smp.sample_valid <= 1'b1;
          end else begin
            overrun <= 1'b1;
          end
        end else if (smp.sample_valid && smp.sample_ready) begin
          smp.sample_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_receiver.sv
// Scoreboard bench for i2s_receiver: an I2S master model streams slots, expected pairs are queued at drive time.
// A negedge monitor pops and compares on every accepted pair; direct checks cover reset, lock, overrun and latency.
module tb_i2s_receiver;
  logic       clk;
  logic       rst;
  logic       enable;
  logic [3:0] sample_size;
  logic       sck_in;
  logic       ws_in;
  logic       sd_in;
  logic       overrun;
  logic       locked;

  i2s_receiver_if smp_if();

  i2s_receiver #(.SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .sample_size (sample_size),
    .sck_in      (sck_in),
    .ws_in       (ws_in),
    .sd_in       (sd_in),
    .smp         (smp_if),
    .overrun     (overrun),
    .locked      (locked)
  );

  int checks   = 0;
  int failures = 0;

  bit          ws_q[$];
  bit          sd_q[$];
  logic [63:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input logic [31:0] d, input int k, input int n);
    logic [63:0] w;
    w = {32'd0, d};
    if (k >= n) w = w >> (k - n);
    else        w = w << (n - k);
    if (n < 32) w = w & ((64'd1 << n) - 64'd1);
    return w[31:0];
  endfunction

  task automatic push_word(input bit ch, input logic [31:0] d, input int k);
    for (int i = k - 1; i >= 0; i--) begin
      ws_q.push_back(ch);
      sd_q.push_back(d[i]);
    end
  endtask

  task automatic push_frame(input logic [31:0] l, input logic [31:0] r, input int k, input int n,
                            input bit expect_out);
    push_word(1'b0, l, k);
    push_word(1'b1, r, k);
    if (expect_out) exp_q.push_back({exp_word(l, k, n), exp_word(r, k, n)});
  endtask

  // WS leads data by one slot: each slot carries the channel flag of the slot after it.
  task automatic play(input int n);
    bit ch;
    @(posedge clk);
    #1;
    for (int i = 0; i < n && sd_q.size() > 0; i++) begin
      sck_in = 1'b0;
      sd_in  = sd_q.pop_front();
      ch     = ws_q.pop_front();
      ws_in  = (ws_q.size() > 0) ? ws_q[0] : 1'b0;
      #40;
      sck_in = 1'b1;
      #40;
    end
  endtask

  // Word length is latched on the closing slot, so the next block's size goes in just before it.
  task automatic finish_block(input logic [3:0] next_size);
    play(sd_q.size() - 1);
    sample_size = next_size;
    play(1);
  endtask

  always @(negedge clk) begin
    if (!rst && smp_if.sample_valid && smp_if.sample_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pair", smp_if.sample_left, 32'hxxxx_xxxx);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("pair_left", smp_if.sample_left, e[63:32]);
        check("pair_right", smp_if.sample_right, e[31:0]);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ch;
    rst                 = 1'b1;
    enable              = 1'b0;
    sample_size         = 4'd3;
    sck_in              = 1'b0;
    ws_in               = 1'b0;
    sd_in               = 1'b0;
    smp_if.sample_ready = 1'b1;
    #22;
    check("rst_valid", {31'd0, smp_if.sample_valid}, 32'd0);
    check("rst_left", smp_if.sample_left, 32'd0);
    check("rst_right", smp_if.sample_right, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    check("rst_locked", {31'd0, locked}, 32'd0);
    rst    = 1'b0;
    enable = 1'b1;
    repeat (3) @(posedge clk);

    // 16-bit frames, lock acquisition on the first WS 1->0
    push_word(1'b1, 32'd0, 4);
    play(3);
    repeat (4) @(posedge clk);
    check("locked_before_ws", {31'd0, locked}, 32'd0);
    play(1);
    repeat (4) @(posedge clk);
    check("locked_after_ws", {31'd0, locked}, 32'd1);
    push_frame(32'hA5C3, 32'h1234, 16, 16, 1'b1);
    push_frame(32'hFFFF, 32'h0001, 16, 16, 1'b1);
    push_frame(32'h8000, 32'h7FFE, 16, 16, 1'b1);
    finish_block(4'd5);

    // 32-bit words exercising MSB and LSB
    push_frame(32'h8000_0001, 32'hFFFF_FFFE, 32, 32, 1'b1);
    finish_block(4'd0);

    // 8-bit words: surplus slots ignored, short words zero-filled at the bottom
    push_frame(32'h3CA7, 32'h5AFF, 16, 8, 1'b1);
    push_frame(32'h2D, 32'h13, 6, 8, 1'b1);
    finish_block(4'd3);
    repeat (10) @(posedge clk);
    check("sb_empty_basic", exp_q.size(), 32'd0);

    // enable rising mid-right: partial frame must not appear
    enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("dis_valid", {31'd0, smp_if.sample_valid}, 32'd0);
    check("dis_locked", {31'd0, locked}, 32'd0);
    push_frame(32'hFFFF, 32'h0F0F, 16, 16, 1'b0);
    play(24);
    enable = 1'b1;
    repeat (3) @(posedge clk);
    play(sd_q.size());
    push_frame(32'h1357, 32'h2468, 16, 16, 1'b1);
    finish_block(4'd3);
    repeat (10) @(posedge clk);
    check("sb_empty_enable", exp_q.size(), 32'd0);

    // backpressure: second pair dropped, first held, overrun sticky
    smp_if.sample_ready = 1'b0;
    push_frame(32'h1111, 32'h2222, 16, 16, 1'b1);
    push_frame(32'h3333, 32'h4444, 16, 16, 1'b0);
    finish_block(4'd3);
    repeat (4) @(posedge clk);
    #1;
    check("bp_valid", {31'd0, smp_if.sample_valid}, 32'd1);
    check("bp_overrun", {31'd0, overrun}, 32'd1);
    check("bp_left_held", smp_if.sample_left, 32'h1111);
    check("bp_right_held", smp_if.sample_right, 32'h2222);
    @(posedge clk);
    #1 smp_if.sample_ready = 1'b1;
    @(posedge clk);
    #1 smp_if.sample_ready = 1'b0;
    check("bp_valid_drop", {31'd0, smp_if.sample_valid}, 32'd0);
    check("bp_overrun_sticky", {31'd0, overrun}, 32'd1);
    check("sb_empty_bp", exp_q.size(), 32'd0);

    // reset mid-left word, then recover on the next full frame
    smp_if.sample_ready = 1'b1;
    push_frame(32'hAAAA, 32'h5555, 16, 16, 1'b0);
    play(8);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_valid", {31'd0, smp_if.sample_valid}, 32'd0);
    check("mid_rst_left", smp_if.sample_left, 32'd0);
    check("mid_rst_right", smp_if.sample_right, 32'd0);
    check("mid_rst_overrun", {31'd0, overrun}, 32'd0);
    check("mid_rst_locked", {31'd0, locked}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    play(sd_q.size());
    push_frame(32'hBEEF, 32'hCAFE, 16, 16, 1'b1);
    play(sd_q.size() - 1);
    sck_in = 1'b0;
    sd_in  = sd_q.pop_front();
    ch     = ws_q.pop_front();
    ws_in  = 1'b0;
    #40;
    sck_in = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 check("lat_edge2_low", {31'd0, smp_if.sample_valid}, 32'd0);
    @(posedge clk);
    #1 check("lat_edge3_high", {31'd0, smp_if.sample_valid}, 32'd1);
    repeat (10) @(posedge clk);
    check("sb_empty_rst", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
